// File: rtl/cache_line_mem_port.sv
// cache_line_mem_port: optionally writes back a victim line, then fetches a line, one beat per command.
// Latency: with a zero-wait memory, fill_done comes 10 edges after acceptance (18 with writeback).
// Backpressure: commands hold stable while mem_cmd_ready is low; req_ready is high only in IDLE; responses are never stalled.
//
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   req_valid/req_ready     - line service request handshake from the cache controller
//   req_writeback           - write the victim line back before fetching
//   fetchAddress            - line to fetch (low offset bits ignored)
//   writeBackAddress/Data   - victim line address (low offset bits ignored) and contents
//   fetchedData, fill_done  - reassembled line and its one-cycle completion pulse
//   busy                    - any state other than IDLE
//   mem_cmd_*               - beat command channel (valid/ready, write flag, byte address, write data)
//   mem_rvalid, mem_rdata   - in-order read responses
module cache_line_mem_port #(
    parameter int COUNTER_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_writeback,
    input  logic [ADDRESS_WIDTH-1:0]  fetchAddress,
    input  logic [ADDRESS_WIDTH-1:0]  writeBackAddress,
    input  logic [8*BLOCK_SIZE-1:0]   writeBackData,
    output logic [8*BLOCK_SIZE-1:0]   fetchedData,
    output logic                      fill_done,
    output logic                      busy,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_write,
    output logic [ADDRESS_WIDTH-1:0]  mem_cmd_addr,
    output logic [MEM_WIDTH-1:0]      mem_cmd_wdata,
    input  logic                      mem_rvalid,
    input  logic [MEM_WIDTH-1:0]      mem_rdata
);

    localparam int LINE_BITS  = 8 * BLOCK_SIZE;
    localparam int BEATS      = LINE_BITS / MEM_WIDTH;
    localparam int BEAT_BYTES = MEM_WIDTH / 8;
    localparam int CNT_W      = $clog2(BEATS) + 1;
    localparam int OFFSET_W   = $clog2(BLOCK_SIZE);
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    localparam logic [CNT_W-1:0]         LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << OFFSET_W;

    // Counter and data widths are fixed by the controller; only reject shapes
    // that cannot be split into whole byte-aligned beats.
    if (COUNTER_WIDTH <= 0 || DATA_WIDTH <= 0 || MEM_WIDTH % 8 != 0 ||
        LINE_BITS % MEM_WIDTH != 0 || BEATS < 2) begin : g_param_check
        $error("cache_line_mem_port: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [ADDRESS_WIDTH-1:0] fetch_base;
    logic [ADDRESS_WIDTH-1:0] wb_base;
    logic [LINE_BITS-1:0]     wb_line;
    logic [LINE_BITS-1:0]     fill_line;
    logic [CNT_W-1:0]         cmd_cnt;
    logic [CNT_W-1:0]         rsp_cnt;

    logic                     req_take;
    logic                     cmd_fire;
    logic                     cmd_last;
    logic                     rsp_take;
    logic                     rsp_last;
    logic [ADDRESS_WIDTH-1:0] beat_off;
    logic [MEM_WIDTH-1:0]     wb_beat;

    // req_ready follows rst_n combinationally so nothing is accepted during reset.
    assign req_ready   = (state == S_IDLE) && rst_n;
    assign req_take    = req_valid && req_ready;
    assign cmd_fire    = mem_cmd_valid && mem_cmd_ready;
    assign cmd_last    = (cmd_cnt == LAST_BEAT);
    // Responses outside READ/WAIT cannot belong to this fill and are dropped.
    assign rsp_take    = mem_rvalid && ((state == S_READ) || (state == S_WAIT));
    assign rsp_last    = (rsp_cnt == LAST_BEAT);
    assign beat_off    = ADDRESS_WIDTH'(cmd_cnt) << BEAT_SHIFT;
    assign fetchedData = fill_line;

    // Victim beat selected by the command counter, beat 0 in the line LSBs.
    always_comb begin
        wb_beat = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (cmd_cnt == CNT_W'(i)) begin
                wb_beat = wb_line[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_take) begin
                    state_nxt = req_writeback ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (cmd_fire && cmd_last) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                // A final response can only coincide with the final command,
                // so finishing the line takes priority over entering WAIT.
                if (rsp_take && rsp_last) begin
                    state_nxt = S_DONE;
                end else if (cmd_fire && cmd_last) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_take && rsp_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs. Command fields depend only on state and registered counters,
    // so they cannot move while a command is stalled.
    always_comb begin
        busy          = 1'b1;
        fill_done     = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_write = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_wdata = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_WRITE: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_write = 1'b1;
                mem_cmd_addr  = wb_base + beat_off;
                mem_cmd_wdata = wb_beat;
            end
            S_READ: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = fetch_base + beat_off;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                fill_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request capture, beat counters and line reassembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_base <= '0;
            wb_base    <= '0;
            wb_line    <= '0;
            fill_line  <= '0;
            cmd_cnt    <= '0;
            rsp_cnt    <= '0;
        end else if (req_take) begin
            fetch_base <= fetchAddress & ALIGN_MASK;
            wb_base    <= writeBackAddress & ALIGN_MASK;
            wb_line    <= writeBackData;
            cmd_cnt    <= '0;
            rsp_cnt    <= '0;
        end else begin
            // Clearing on the last beat leaves the counter at zero for the
            // read phase that follows a writeback.
            if (cmd_fire) begin
                cmd_cnt <= cmd_last ? '0 : cmd_cnt + CNT_W'(1);
            end
            if (rsp_take) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (rsp_cnt == CNT_W'(i)) begin
                        fill_line[i*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata;
                    end
                end
                rsp_cnt <= rsp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_line_mem_port.sv
// tb_cache_line_mem_port: directed bench for cache_line_mem_port with a small in-order memory model.
// Latency: fill latency is measured in clock edges from request acceptance to the edge ending fill_done.
// Backpressure: the memory model can drop cmd_ready at random and delay responses 1..5 cycles.
module tb_cache_line_mem_port;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_writeback;
    logic [31:0]  fetchAddress;
    logic [31:0]  writeBackAddress;
    logic [255:0] writeBackData;
    logic [255:0] fetchedData;
    logic         fill_done;
    logic         busy;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready;
    logic         mem_cmd_write;
    logic [31:0]  mem_cmd_addr;
    logic [31:0]  mem_cmd_wdata;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    always #5 clk = ~clk;

    cache_line_mem_port dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_writeback    (req_writeback),
        .fetchAddress     (fetchAddress),
        .writeBackAddress (writeBackAddress),
        .writeBackData    (writeBackData),
        .fetchedData      (fetchedData),
        .fill_done        (fill_done),
        .busy             (busy),
        .mem_cmd_valid    (mem_cmd_valid),
        .mem_cmd_ready    (mem_cmd_ready),
        .mem_cmd_write    (mem_cmd_write),
        .mem_cmd_addr     (mem_cmd_addr),
        .mem_cmd_wdata    (mem_cmd_wdata),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int rsp_seen = 0;
    bit bp_en   = 1'b0;
    bit spur_en = 1'b0;

    logic [31:0] log_addr [$];
    logic        log_wr   [$];
    logic [31:0] log_data [$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and response monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (fill_done) done_cnt++;
        if (rst_n && mem_rvalid && busy && !mem_cmd_write && !fill_done) rsp_seen++;
    end

    // Memory model: read data equals the beat address. Decisions on the
    // command channel are taken at the negedge; inputs change just after posedge.
    initial begin
        logic [31:0] rq_data [$];
        int          rq_due  [$];
        bit          stall_prev;
        logic [64:0] stall_snap;
        mem_cmd_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        stall_prev    = 1'b0;
        stall_snap    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rq_data.delete();
                rq_due.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("cmd_stable", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata},
                             {1'b1, stall_snap});
                end
                stall_prev = mem_cmd_valid && !mem_cmd_ready;
                stall_snap = {mem_cmd_write, mem_cmd_addr, mem_cmd_wdata};
                if (mem_cmd_valid && mem_cmd_ready) begin
                    log_addr.push_back(mem_cmd_addr);
                    log_wr.push_back(mem_cmd_write);
                    log_data.push_back(mem_cmd_write ? mem_cmd_wdata : 32'h0);
                    if (!mem_cmd_write) begin
                        rq_data.push_back(mem_cmd_addr);
                        rq_due.push_back(cyc + (bp_en ? int'($urandom_range(5, 1)) : 1));
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_cmd_ready = !bp_en || ($urandom_range(1, 0) == 1);
            mem_rvalid    = 1'b0;
            mem_rdata     = '0;
            if (rst_n && rq_data.size() > 0 && rq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rq_data.pop_front();
                void'(rq_due.pop_front());
            end else if (spur_en && (!busy || mem_cmd_write)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    function automatic logic [255:0] addr_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(4 * i);
        return l;
    endfunction

    function automatic logic [255:0] seq_line(input logic [31:0] first);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = first + 32'(i);
        return l;
    endfunction

    // Called and returns just after a posedge; t_acc is the accepting edge.
    task automatic issue(input bit wb, input logic [31:0] fa, input logic [31:0] wa,
                         input logic [255:0] wd, output int t_acc);
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
        req_valid        = 1'b1;
        req_writeback    = wb;
        fetchAddress     = fa;
        writeBackAddress = wa;
        writeBackData    = wd;
        t_acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) t_acc = cyc + 1;
            @(posedge clk);
            #1;
            if (t_acc >= 0) break;
        end
        req_valid = 1'b0;
        if (t_acc < 0) check_eq("req_accept_timeout", 0, 1);
    endtask

    // dc is the edge that ends the fill_done cycle.
    task automatic wait_done(output int dc);
        dc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (fill_done) dc = cyc + 1;
            @(posedge clk);
            #1;
            if (dc >= 0) break;
        end
        if (dc < 0) check_eq("fill_done_timeout", 0, 1);
    endtask

    task automatic check_log(input string tag, input bit wb, input logic [31:0] wa,
                             input logic [31:0] fbase, input logic [31:0] wd0);
        int n;
        int nw;
        n  = wb ? 16 : 8;
        nw = wb ? 8 : 0;
        check_eq({tag, "_hs_count"}, log_addr.size(), n);
        for (int j = 0; j < n && j < log_addr.size(); j++) begin
            if (j < nw) begin
                check_eq($sformatf("%s_wr%0d", tag, j), {log_wr[j], log_addr[j], log_data[j]},
                         {1'b1, wa + 32'(4 * j), wd0 + 32'(j)});
            end else begin
                check_eq($sformatf("%s_rd%0d", tag, j - nw), {log_wr[j], log_addr[j], log_data[j]},
                         {1'b0, fbase + 32'(4 * (j - nw)), 32'h0});
            end
        end
    endtask

    initial begin
        int t;
        int dc;
        int d0;
        int r0;
        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_writeback    = 1'b0;
        fetchAddress     = '0;
        writeBackAddress = '0;
        writeBackData    = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fill_done", fill_done, 0);
        check_eq("rst_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata}, 0);
        check_eq("rst_fetchedData", fetchedData, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", req_ready, 1);
        @(posedge clk);
        #1;

        // Read-only fill, best-case memory.
        d0 = done_cnt;
        issue(1'b0, 32'h1000_0014, 32'h0, '0, t);
        @(negedge clk);
        check_eq("rd_first_cycle", {busy, mem_cmd_valid, mem_cmd_write}, 3'b110);
        @(posedge clk);
        #1;
        wait_done(dc);
        check_eq("rd_latency", dc - t, 10);
        check_eq("rd_line", fetchedData, addr_line(32'h1000_0000));
        check_log("rd", 1'b0, 32'h0, 32'h1000_0000, 32'h0);
        @(negedge clk);
        check_eq("rd_after_done", {req_ready, fill_done, busy}, 3'b100);
        check_eq("rd_done_pulses", done_cnt - d0, 1);
        @(posedge clk);
        #1;

        // Writeback then fill.
        d0 = done_cnt;
        issue(1'b1, 32'h3000_0040, 32'h2000_0020, seq_line(32'hA0), t);
        @(negedge clk);
        check_eq("wb_first_cycle", {busy, mem_cmd_valid, mem_cmd_write}, 3'b111);
        @(posedge clk);
        #1;
        wait_done(dc);
        check_eq("wb_latency", dc - t, 18);
        check_eq("wb_line", fetchedData, addr_line(32'h3000_0040));
        check_log("wb", 1'b1, 32'h2000_0020, 32'h3000_0040, 32'hA0);
        check_eq("wb_done_pulses", done_cnt - d0, 1);

        // Spurious responses in IDLE and WRITE.
        spur_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("spur_idle_line", fetchedData, addr_line(32'h3000_0040));
        @(posedge clk);
        #1;
        issue(1'b1, 32'h4000_0000, 32'h5000_0040, seq_line(32'hC0), t);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_cmd_valid && !mem_cmd_write) break;
        end
        check_eq("spur_write_line", fetchedData, addr_line(32'h3000_0040));
        @(posedge clk);
        #1;
        spur_en = 1'b0;
        wait_done(dc);
        check_eq("spur_fill_line", fetchedData, addr_line(32'h4000_0000));
        check_log("spur", 1'b1, 32'h5000_0040, 32'h4000_0000, 32'hC0);

        // Random command back-pressure and response delay.
        bp_en = 1'b1;
        d0 = done_cnt;
        issue(1'b1, 32'h7000_0104, 32'h7100_0000, seq_line(32'hB0), t);
        wait_done(dc);
        bp_en = 1'b0;
        check_eq("bp_line", fetchedData, addr_line(32'h7000_0100));
        check_log("bp", 1'b1, 32'h7100_0000, 32'h7000_0100, 32'hB0);
        check_eq("bp_done_pulses", done_cnt - d0, 1);

        // Reset in the middle of a fill.
        d0 = done_cnt;
        r0 = rsp_seen;
        issue(1'b0, 32'h6000_0000, 32'h0, '0, t);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_seen - r0 >= 3) break;
        end
        check_eq("mid_rsp_seen", (rsp_seen - r0 >= 3), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_rst_state", {busy, fill_done, req_ready, mem_cmd_valid}, 4'b0000);
        check_eq("mid_rst_line", fetchedData, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_no_done", done_cnt - d0, 0);
        issue(1'b0, 32'h1000_0014, 32'h0, '0, t);
        wait_done(dc);
        check_eq("post_rst_latency", dc - t, 10);
        check_eq("post_rst_line", fetchedData, addr_line(32'h1000_0000));

        // Address wrap at the top of the address space.
        issue(1'b0, 32'hFFFF_FFF0, 32'h0, '0, t);
        wait_done(dc);
        check_log("wrap", 1'b0, 32'h0, 32'hFFFF_FFE0, 32'h0);
        check_eq("wrap_line", fetchedData, addr_line(32'hFFFF_FFE0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
